button_color_cycler: RTL

BUTTON_COLOR_CYCLER -- requirements
Module: button_color_cycler

---
 rtl/color_pkg.sv | 15 +
 rtl/button_debouncer.sv | 36 +++
 rtl/button_color_cycler.sv | 84 ++++++++
 3 files changed

// File: rtl/color_pkg.sv
// color_pkg: color state encoding and the advance order shared by the cycler
package color_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } color_t;

    function automatic color_t next_color(input color_t c);
        return color_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer plus counting debounce with a rising-edge pulse
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic debounced,
    output logic rise_pulse
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync;
    logic [15:0] cnt;

    // synchronize, then accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync       <= '0;
            cnt        <= '0;
            debounced  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync       <= {sync[0], button};
            rise_pulse <= 1'b0;
            if (sync[1] == debounced) cnt <= '0;
            else if (cnt == LAST) begin
                cnt        <= '0;
                debounced  <= sync[1];
                rise_pulse <= sync[1];
            end else cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/button_color_cycler.sv
// button_color_cycler: push-button color cycler with PWM LEDs; LONG_PRESS_EN adds hold-to-off
module button_color_cycler
    import color_pkg::*;
#(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         button,
    input  logic [N-1:0] brightness,
    output color_t       state,
    output logic         pressed,
    output logic         led_r,
    output logic         led_g,
    output logic         led_b
);

    logic         debounced;
    logic         rise;
    logic         long_hit;
    logic [N-1:0] pwm_cnt;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .debounced  (debounced),
        .rise_pulse (rise)
    );

`ifdef LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES) + 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt;

    assign long_hit = debounced && (long_cnt == LONG_LAST - LW'(1));

    // count the debounced hold, saturating so the forced OFF fires once per hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) long_cnt <= '0;
        else if (!debounced) long_cnt <= '0;
        else if (long_cnt != LONG_LAST) long_cnt <= long_cnt + LW'(1);
    end
`else
    logic unused_long;
    assign unused_long = ^LONG_CYCLES;
    assign long_hit    = 1'b0;
`endif

    // color FSM: advance on each accepted press, long hold forces OFF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= OFF;
            pressed <= 1'b0;
        end else begin
            pressed <= rise;
            state   <= long_hit ? OFF : rise ? next_color(state) : state;
        end
    end

    // free-running PWM counter, frozen while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_cnt <= '0;
        else if (ena) pwm_cnt <= pwm_cnt + N'(1);
    end

    // LED drive: only the active color lights, for the first brightness counts of each period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else if (ena) begin
            led_r <= (state == RED)   && (pwm_cnt < brightness);
            led_g <= (state == GREEN) && (pwm_cnt < brightness);
            led_b <= (state == BLUE)  && (pwm_cnt < brightness);
        end
    end

endmodule
